// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_arbiter
//  Purpose  : Shares one SPI byte-transaction engine between NREQ requesters.
//             Round-robin grant, one transaction at a time, a minimum idle gap
//             after each transaction, read data and a one-cycle ack returned
//             to the owner.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             req_i/req_addr_i/req_wdata_i/req_read_i - per-requester request
//                                     (byte slice i = [8i+7:8i])
//             gnt_o/ack_o/err_o      - one-hot owner, completion, abort flags
//             rdata_o                - byte captured at completion, held
//             spi_enable_o/spi_read_o/spi_addr_o/spi_wdata_o - to engine
//             spi_done_i/spi_rdata_i - from engine
//  Options  : define SPI_ARB_TIMEOUT_EN to abort a transaction that sees no
//             spi_done within TIMEOUT_CYCLES cycles (ack and err pulse).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
    parameter int NREQ           = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_i,
    input  logic [8*NREQ-1:0]   req_addr_i,
    input  logic [8*NREQ-1:0]   req_wdata_i,
    input  logic [NREQ-1:0]     req_read_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     ack_o,
    output logic [NREQ-1:0]     err_o,
    output logic [7:0]          rdata_o,
    output logic                spi_enable_o,
    output logic                spi_read_o,
    output logic [7:0]          spi_addr_o,
    output logic [7:0]          spi_wdata_o,
    input  logic                spi_done_i,
    input  logic [7:0]          spi_rdata_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    if (NREQ < 2 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_arbiter: illegal parameter value");
    end

    logic [1:0]      state_q,  state_d;
    logic [PW-1:0]   ptr_q,    ptr_d;      // last winner; also the current owner
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] ack_q,    ack_d;
    logic [7:0]      rdata_q,  rdata_d;
    logic            en_q,     en_d;
    logic            read_q,   read_d;
    logic [7:0]      addr_q,   addr_d;
    logic [7:0]      wdata_q,  wdata_d;
    logic [GW-1:0]   gap_q,    gap_d;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   tmo_q,    tmo_d;
    logic [NREQ-1:0] err_q,    err_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: first requester after ptr_q, wrapping. A requester
    // whose ack is high this cycle is masked so it cannot be re-issued
    // before it has seen its completion.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] w_req_m;
    logic [PW:0]     w_idx;
    logic [PW-1:0]   w_win;
    logic            w_any;

    always_comb begin
        w_req_m = req_i & ~ack_q;
        w_idx   = '0;
        w_win   = ptr_q;
        w_any   = 1'b0;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = {1'b0, ptr_q} + (PW + 1)'(k);
            if (w_idx >= (PW + 1)'(NREQ)) begin
                w_idx = w_idx - (PW + 1)'(NREQ);
            end
            if (w_req_m[w_idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[PW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        en_d    = en_q;
        read_d  = read_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gap_d   = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = '0;
`endif

        case (state_q)
            c_IDLE: begin
                if (w_any) begin
                    state_d        = c_XFER;
                    gnt_d          = '0;
                    gnt_d[w_win]   = 1'b1;
                    en_d           = 1'b1;
                    addr_d         = req_addr_i[8*w_win +: 8];
                    wdata_d        = req_wdata_i[8*w_win +: 8];
                    read_d         = req_read_i[w_win];
                    ptr_d          = w_win;
`ifdef SPI_ARB_TIMEOUT_EN
                    tmo_d          = '0;
`endif
                end
            end

            c_XFER: begin
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_d = tmo_q + TW'(1);
`endif
                // Completion takes priority over a coincident timeout.
                if (spi_done_i) begin
                    en_d         = 1'b0;
                    gnt_d        = '0;
                    ack_d[ptr_q] = 1'b1;
                    rdata_d      = spi_rdata_i;
                    gap_d        = GW'(GAP_CYCLES);
                    state_d      = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    en_d         = 1'b0;
                    gnt_d        = '0;
                    ack_d[ptr_q] = 1'b1;
                    err_d[ptr_q] = 1'b1;
                    rdata_d      = 8'h00;
                    gap_d        = GW'(GAP_CYCLES);
                    state_d      = (GAP_CYCLES == 0) ? c_IDLE : c_GAP;
                end
`endif
            end

            c_GAP: begin
                // Loaded with GAP_CYCLES; the cycle showing 1 is the last GAP cycle.
                if (gap_q <= GW'(1)) begin
                    state_d = c_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= 8'h00;
            en_q    <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            gap_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gap_q   <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign gnt_o        = gnt_q;
    assign ack_o        = ack_q;
    assign rdata_o      = rdata_q;
    assign spi_enable_o = en_q;
    assign spi_read_o   = read_q;
    assign spi_addr_o   = addr_q;
    assign spi_wdata_o  = wdata_q;

`ifdef SPI_ARB_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_arbiter
//  Purpose  : Self-checking bench for spi_arbiter. A transaction-level model
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;

    localparam int NREQ = 2;
    localparam int GAP  = 4;
    localparam int TMO  = 16;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int T1_LAT = 12;
`else
    localparam int T1_LAT = 20;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [8*NREQ-1:0]   req_addr = '0;
    logic [8*NREQ-1:0]   req_wdata = '0;
    logic [NREQ-1:0]     req_read = '0;
    logic [NREQ-1:0]     gnt_o, ack_o, err_o;
    logic [7:0]          rdata_o;
    logic                spi_enable_o, spi_read_o;
    logic [7:0]          spi_addr_o, spi_wdata_o;
    logic                spi_done = 1'b0;
    logic [7:0]          spi_rdata = 8'h00;

    spi_arbiter #(
        .NREQ           (NREQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_read_i   (req_read),
        .gnt_o        (gnt_o),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .spi_enable_o (spi_enable_o),
        .spi_read_o   (spi_read_o),
        .spi_addr_o   (spi_addr_o),
        .spi_wdata_o  (spi_wdata_o),
        .spi_done_i   (spi_done),
        .spi_rdata_i  (spi_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Engine stand-in: answers the lat-th enabled cycle with spi_done and
    // rdata = addr ^ 0x87. Only drives spi_done while eng_on is set.
    // ------------------------------------------------------------------
    logic eng_on  = 1'b0;
    int   eng_lat = 1;
    int   ecnt    = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (eng_on) begin
                if (spi_done) begin
                    spi_done = 1'b0;
                    ecnt     = 0;
                end else if (spi_enable_o) begin
                    ecnt++;
                    if (ecnt == eng_lat) begin
                        spi_done  = 1'b1;
                        spi_rdata = spi_addr_o ^ 8'h87;
                    end
                end else begin
                    ecnt = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level model: owner, the cycle the next request may be
    // accepted, and the cycle of the current grant.
    // ------------------------------------------------------------------
    int              cyc = 0;
    int              m_owner = -1;
    int              m_allow = 0;
    int              m_gcyc  = 0;
    int              m_ptr   = NREQ - 1;
    logic [NREQ-1:0] m_gnt = '0, m_ack = '0, m_err = '0;
    logic [7:0]      m_rdata = 8'h00, m_addr = 8'h00, m_wdata = 8'h00;
    logic            m_en = 1'b0, m_read = 1'b0;

    task automatic m_finish();
        m_gnt   = '0;
        m_en    = 1'b0;
        m_owner = -1;
        m_allow = cyc + GAP + 1;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] ack_old;
        logic [NREQ-1:0] cand;
        int w;
        int i;
        cyc++;
        ack_old = m_ack;
        m_ack   = '0;
        m_err   = '0;
        if (reset) begin
            m_owner = -1;
            m_allow = cyc + 1;
            m_ptr   = NREQ - 1;
            m_gnt   = '0;
            m_rdata = 8'h00;
            m_addr  = 8'h00;
            m_wdata = 8'h00;
            m_en    = 1'b0;
            m_read  = 1'b0;
        end else if (m_owner >= 0) begin
            if (spi_done) begin
                m_ack[m_owner] = 1'b1;
                m_rdata        = spi_rdata;
                m_finish();
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (cyc == m_gcyc + TMO) begin
                m_ack[m_owner] = 1'b1;
                m_err[m_owner] = 1'b1;
                m_rdata        = 8'h00;
                m_finish();
            end
`endif
        end else if (cyc >= m_allow) begin
            cand = req & ~ack_old;
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (w < 0 && cand[i]) w = i;
            end
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = w;
                m_gcyc  = cyc;
                m_gnt   = '0;
                m_gnt[w] = 1'b1;
                m_en    = 1'b1;
                m_addr  = req_addr[8*w +: 8];
                m_wdata = req_wdata[8*w +: 8];
                m_read  = req_read[w];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_gnt",   32'(gnt_o),        32'(m_gnt));
            chk("m_ack",   32'(ack_o),        32'(m_ack));
            chk("m_err",   32'(err_o),        32'(m_err));
            chk("m_rdata", 32'(rdata_o),      32'(m_rdata));
            chk("m_en",    32'(spi_enable_o), 32'(m_en));
            if (m_en) begin
                chk("m_addr",  32'(spi_addr_o),  32'(m_addr));
                chk("m_wdata", 32'(spi_wdata_o), 32'(m_wdata));
                chk("m_read",  32'(spi_read_o),  32'(m_read));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    int n;
    int grants;
    int lowcnt;
    logic prev_en;
    logic bad;
    logic [7:0] exp_addr [4];
    logic [1:0] exp_gnt  [4];

    initial begin
        exp_addr[0] = 8'h10; exp_addr[1] = 8'h20; exp_addr[2] = 8'h10; exp_addr[3] = 8'h20;
        exp_gnt[0]  = 2'b01; exp_gnt[1]  = 2'b10; exp_gnt[2]  = 2'b01; exp_gnt[3]  = 2'b10;

        // ---- reset state ----
        tick(3);
        reset = 1'b0;
        chk("rst_gnt",   32'(gnt_o), 0);
        chk("rst_en",    32'(spi_enable_o), 0);
        chk("rst_ack",   32'(ack_o), 0);
        chk("rst_rdata", 32'(rdata_o), 0);
        chk("rst_addr",  32'(spi_addr_o), 0);
        tick(2);

        // ---- 1: single read from requester 0 ----
        req_addr[7:0]  = 8'h22;
        req_wdata[7:0] = 8'h5C;
        req_read[0]    = 1'b1;
        req[0]         = 1'b1;
        eng_on         = 1'b1;
        eng_lat        = T1_LAT;
        tick(1);
        chk("t1_gnt",  32'(gnt_o), 32'h1);
        chk("t1_addr", 32'(spi_addr_o), 32'h22);
        chk("t1_read", 32'(spi_read_o), 32'h1);
        chk("t1_en",   32'(spi_enable_o), 32'h1);
        req[0] = 1'b0;
        n = 0;
        while (!ack_o[0] && n < 60) begin
            tick(1);
            n++;
        end
        chk("t1_latency", 32'(n), 32'(T1_LAT));
        chk("t1_ack",   32'(ack_o), 32'h1);
        chk("t1_rdata", 32'(rdata_o), 32'hA5);
        tick(1);
        chk("t1_ack_pulse", 32'(ack_o), 32'h0);
        chk("t1_rdata_hold", 32'(rdata_o), 32'hA5);
        tick(2);

        // ---- 2/3: both requesting from reset, alternate, 5-cycle gaps ----
        reset           = 1'b1;
        req_addr        = 16'h2010;
        req_wdata       = 16'hB0A0;
        req_read        = 2'b00;
        req             = 2'b11;
        eng_lat         = 3;
        tick(2);
        reset = 1'b0;
        grants  = 0;
        lowcnt  = 0;
        prev_en = 1'b0;
        n       = 0;
        while (grants < 4 && n < 200) begin
            tick(1);
            n++;
            if (spi_enable_o && !prev_en) begin
                chk("t2_gnt_order", 32'(gnt_o), 32'(exp_gnt[grants]));
                chk("t2_addr",      32'(spi_addr_o), 32'(exp_addr[grants]));
                if (grants > 0) chk("t3_gap_len", 32'(lowcnt), 32'(GAP + 1));
                grants++;
                lowcnt = 0;
            end else if (!spi_enable_o) begin
                lowcnt++;
            end
            prev_en = spi_enable_o;
        end
        chk("t2_grants", 32'(grants), 32'd4);
        req = 2'b00;

        // ---- 4: owner drops req mid-XFER; done in IDLE ignored ----
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        req_addr[15:8] = 8'h33;
        req_read[1]    = 1'b1;
        req[1]         = 1'b1;
        eng_lat        = 10;
        tick(1);
        chk("t4_gnt",  32'(gnt_o), 32'h2);
        chk("t4_addr", 32'(spi_addr_o), 32'h33);
        tick(3);
        req[1] = 1'b0;
        n = 0;
        while (!ack_o[1] && n < 20) begin
            tick(1);
            n++;
        end
        chk("t4_ack", 32'(ack_o), 32'h2);
        tick(8);
        eng_on    = 1'b0;
        spi_done  = 1'b1;
        spi_rdata = 8'hEE;
        tick(1);
        spi_done = 1'b0;
        chk("t4_idle_ack",   32'(ack_o), 32'h0);
        chk("t4_idle_en",    32'(spi_enable_o), 32'h0);
        chk("t4_idle_rdata", 32'(rdata_o), 32'hB4);
        tick(2);
        chk("t4_idle_gnt",   32'(gnt_o), 32'h0);

        // ---- 5: reset during XFER ----
        eng_on         = 1'b1;
        eng_lat        = 50;
        req_addr       = 16'h6655;
        req            = 2'b11;
        tick(1);
        chk("t5_gnt", 32'(gnt_o), 32'h1);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("t5_rst_en",  32'(spi_enable_o), 32'h0);
        chk("t5_rst_gnt", 32'(gnt_o), 32'h0);
        chk("t5_rst_ack", 32'(ack_o), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("t5_regrant", 32'(gnt_o), 32'h1);
        reset = 1'b1;
        req   = 2'b00;
        tick(2);
        reset = 1'b0;
        tick(1);

        // ---- 6: engine never answers ----
        eng_on        = 1'b0;
        spi_done      = 1'b0;
        req_addr[7:0] = 8'h44;
        req[0]        = 1'b1;
        tick(1);
        chk("t6_gnt", 32'(gnt_o), 32'h1);
        req[0] = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        tick(TMO - 1);
        chk("t6_pre_ack", 32'(ack_o), 32'h0);
        chk("t6_pre_en",  32'(spi_enable_o), 32'h1);
        tick(1);
        chk("t6_ack",   32'(ack_o), 32'h1);
        chk("t6_err",   32'(err_o), 32'h1);
        chk("t6_rdata", 32'(rdata_o), 32'h0);
        tick(1);
        chk("t6_err_pulse", 32'(err_o), 32'h0);
`else
        bad = 1'b0;
        repeat (1100) begin
            tick(1);
            if (ack_o != '0 || err_o != '0 || !spi_enable_o) bad = 1'b1;
        end
        chk("t6_hold", 32'(bad), 32'h0);
`endif
        reset = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
